// File: rtl/router_fsm_np.sv
// Router write-control FSM for NUM_PORTS output FIFOs.
// Latches the destination, drops bad or timed-out packets, honours soft reset.
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 drop_state,
  output logic                 timeout_pulse
);

  localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    CHECK_PARITY_ERROR = 4'd4,
    FIFO_FULL_STATE    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] dest_q, dest_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [31:0]          addr_ext;
  logic                 addr_ok;
  logic [NUM_PORTS-1:0] addr_oh;

  assign addr_ext = 32'(data_in);
  assign addr_ok  = addr_ext < 32'(NUM_PORTS);
  // Out-of-range shifts truncate to zero, so addr_oh is safe to AND
  assign addr_oh  = NUM_PORTS'(1) << data_in;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    if (state_q != DECODE_ADDRESS && |(soft_reset & dest_q)) begin
      state_d = DECODE_ADDRESS;
    end else begin
      unique case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (!addr_ok) begin
              state_d = DROP_PACKET;
              dest_d  = '0;
            end else begin
              dest_d = addr_oh;
              if (|(fifo_empty & addr_oh)) begin
                state_d = LOAD_FIRST_DATA;
              end else begin
                state_d = WAIT_TILL_EMPTY;
                cnt_d   = '0;
              end
            end
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        WAIT_TILL_EMPTY: begin
          if (|(fifo_empty & dest_q)) begin
            state_d = LOAD_FIRST_DATA;
          end else if (WAIT_TIMEOUT != 0 && cnt_q == LAST) begin
            state_d = DROP_PACKET;
            tmo_d   = 1'b1;
            dest_d  = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DROP_PACKET: begin
          if (!pkt_valid) state_d = DECODE_ADDRESS;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      dest_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dest_sel      = dest_q;
  assign timeout_pulse = tmo_q;
  assign detect_add    = state_q == DECODE_ADDRESS;
  assign lfd_state     = state_q == LOAD_FIRST_DATA;
  assign ld_state      = state_q == LOAD_DATA;
  assign laf_state     = state_q == LOAD_AFTER_FULL;
  assign full_state    = state_q == FIFO_FULL_STATE;
  assign rst_int_reg   = state_q == CHECK_PARITY_ERROR;
  assign drop_state    = state_q == DROP_PACKET;
  assign write_enb_reg = state_q == LOAD_DATA
                      || state_q == LOAD_PARITY
                      || state_q == LOAD_AFTER_FULL;
  assign busy = !(state_q == DECODE_ADDRESS
               || state_q == LOAD_DATA
               || state_q == DROP_PACKET);

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np; dut a has WAIT_TIMEOUT=8, dut b has 4.
// Both share stimulus; state is inferred from the Moore decodes.
module tb_router_fsm_np;

  logic       clk = 1'b0;
  logic       reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;

  logic [2:0] ds_a, ds_b;
  logic busy_a, da_a, lfd_a, ld_a, laf_a, full_a, rir_a, we_a, drop_a, tp_a;
  logic busy_b, da_b, lfd_b, ld_b, laf_b, full_b, rir_b, we_b, drop_b, tp_b;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] S_D = 8'd0, S_LFD = 8'd1, S_LD = 8'd2;
  localparam logic [7:0] S_LP = 8'd3, S_CPE = 8'd4, S_FULL = 8'd5;
  localparam logic [7:0] S_WAIT = 8'd6, S_LAF = 8'd7, S_DROP = 8'd8;

  always #5 clk = ~clk;

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) u_a (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .soft_reset(soft_reset), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .dest_sel(ds_a), .busy(busy_a),
    .detect_add(da_a), .lfd_state(lfd_a), .ld_state(ld_a),
    .laf_state(laf_a), .full_state(full_a), .rst_int_reg(rir_a),
    .write_enb_reg(we_a), .drop_state(drop_a), .timeout_pulse(tp_a)
  );

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) u_b (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .soft_reset(soft_reset), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .dest_sel(ds_b), .busy(busy_b),
    .detect_add(da_b), .lfd_state(lfd_b), .ld_state(ld_b),
    .laf_state(laf_b), .full_state(full_b), .rst_int_reg(rir_b),
    .write_enb_reg(we_b), .drop_state(drop_b), .timeout_pulse(tp_b)
  );

  function automatic logic [7:0] dec(logic d, logic lfd, logic ld,
                                     logic laf, logic fl, logic rir,
                                     logic dr, logic we, logic bz);
    if (d)   return S_D;
    if (lfd) return S_LFD;
    if (ld)  return S_LD;
    if (laf) return S_LAF;
    if (fl)  return S_FULL;
    if (rir) return S_CPE;
    if (dr)  return S_DROP;
    if (we)  return S_LP;
    if (bz)  return S_WAIT;
    return 8'hff;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st_a(input string tag, input logic [7:0] exp);
    chk(tag, dec(da_a, lfd_a, ld_a, laf_a, full_a, rir_a, drop_a,
                 we_a, busy_a), exp);
  endtask

  task automatic st_b(input string tag, input logic [7:0] exp);
    chk(tag, dec(da_b, lfd_b, ld_b, laf_b, full_b, rir_b, drop_b,
                 we_b, busy_b), exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int we_cnt;

  initial begin
    reset = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
    fifo_empty = 3'b111; fifo_full = 1'b0; soft_reset = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    #2;
    do_reset();
    st_a("rst_state", S_D);
    chk("rst_outs", {we_a, busy_a, tp_a, lfd_a, ld_a, drop_a, 2'b00},
        8'h00);
    chk("rst_dest", 8'(ds_a), 8'h00);

    // Normal packet to port 1
    pkt_valid = 1'b1; data_in = 2'd1; we_cnt = 0;
    tick();
    st_a("t1_lfd", S_LFD);
    chk("t1_dest", 8'(ds_a), 8'h02);
    chk("t1_lfd_busy", 8'(busy_a), 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      st_a("t1_ld", S_LD);
      chk("t1_ld_busy", 8'(busy_a), 8'h00);
      if (we_a) we_cnt++;
    end
    pkt_valid = 1'b0;
    tick();
    st_a("t1_lp", S_LP);
    if (we_a) we_cnt++;
    tick();
    st_a("t1_cpe", S_CPE);
    if (we_a) we_cnt++;
    tick();
    st_a("t1_d", S_D);
    chk("t1_we_cycles", 8'(we_cnt), 8'd5);
    tick();
    chk("t1_dest_hold", 8'(ds_a), 8'h02);

    // Wait on busy port 2, then released after 5 cycles
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    tick();
    st_a("t2_wait0", S_WAIT);
    chk("t2_dest", 8'(ds_a), 8'h04);
    data_in = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      st_a("t2_wait", S_WAIT);
      chk("t2_no_tp", 8'(tp_a), 8'h00);
    end
    fifo_empty = 3'b111;
    tick();
    st_a("t2_lfd", S_LFD);
    chk("t2_dest_kept", 8'(ds_a), 8'h04);
    chk("t2_no_tp_end", 8'(tp_a), 8'h00);

    // Timeout on port 0 (dut b, WAIT_TIMEOUT=4)
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b110; we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      st_b("t3_wait", S_WAIT);
      chk("t3_no_tp", 8'(tp_b), 8'h00);
      if (we_b) we_cnt++;
    end
    tick();
    st_b("t3_drop", S_DROP);
    chk("t3_tp", 8'(tp_b), 8'h01);
    chk("t3_dest0", 8'(ds_b), 8'h00);
    if (we_b) we_cnt++;
    tick();
    st_b("t3_drop2", S_DROP);
    chk("t3_tp_off", 8'(tp_b), 8'h00);
    if (we_b) we_cnt++;
    pkt_valid = 1'b0;
    tick();
    st_b("t3_d", S_D);
    chk("t3_no_we", 8'(we_cnt), 8'd0);
    fifo_empty = 3'b111;

    // Out-of-range address 3
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd3;
    tick();
    st_a("t4_drop", S_DROP);
    chk("t4_dest", 8'(ds_a), 8'h00);
    chk("t4_busy", 8'(busy_a), 8'h00);
    chk("t4_we", 8'(we_a), 8'h00);
    tick();
    st_a("t4_drop2", S_DROP);
    pkt_valid = 1'b0;
    tick();
    st_a("t4_d", S_D);

    // FIFO full, resume with low_pkt_valid
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); tick();
    st_a("t5_ld", S_LD);
    fifo_full = 1'b1;
    tick();
    st_a("t5_full", S_FULL);
    chk("t5_full_busy", 8'(busy_a), 8'h01);
    tick();
    st_a("t5_full2", S_FULL);
    fifo_full = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    tick();
    st_a("t5_laf", S_LAF);
    chk("t5_laf_we", 8'(we_a), 8'h01);
    tick();
    st_a("t5_lp", S_LP);
    low_pkt_valid = 1'b0;
    tick();
    st_a("t5_cpe", S_CPE);
    tick();
    st_a("t5_d", S_D);

    // FIFO full, resume with parity_done
    pkt_valid = 1'b1;
    tick(); tick();
    st_a("t5b_ld", S_LD);
    fifo_full = 1'b1;
    tick();
    st_a("t5b_full", S_FULL);
    fifo_full = 1'b0; pkt_valid = 1'b0; parity_done = 1'b1;
    tick();
    st_a("t5b_laf", S_LAF);
    tick();
    st_a("t5b_d", S_D);
    parity_done = 1'b0;

    // Soft reset and hard reset
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); tick();
    st_a("t6_ld", S_LD);
    soft_reset = 3'b001;
    tick();
    st_a("t6_sr_other", S_LD);
    soft_reset = 3'b010;
    tick();
    st_a("t6_sr_sel", S_D);
    soft_reset = 3'b000;
    tick(); tick();
    st_a("t6_ld2", S_LD);
    fifo_full = 1'b1;
    tick();
    st_a("t6_full", S_FULL);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    st_a("t6_rst_d", S_D);
    chk("t6_rst_dest", 8'(ds_a), 8'h00);
    fifo_full = 1'b0; pkt_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
